// File: rtl/add_fed_sched_pkg.sv
// Shared types and defaults for the add_fed scheduler slice.
// The state encoding is fixed because debug tooling decodes it by value.
package add_fed_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 16;
  localparam int DEF_LEN_W = 4;

endpackage

// File: rtl/add_fed.sv
// Free-running feedback accumulator: dout <= dout + din every clock, res clears.
module add_fed #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         res,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  // Accumulate, or clear when res is high
  always_ff @(posedge clk) begin
    if (res) dout <= '0;
    else     dout <= dout + din;
  end

endmodule

// File: rtl/add_fed_sched_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  // Scan from the farthest offset down so the nearest candidate is written last
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int raw_s;
      int cand_s;
      raw_s  = int'(ptr) + k;
      cand_s = (raw_s >= N_REQ) ? (raw_s - N_REQ) : raw_s;
      valid  = valid | req[cand_s];
      idx    = req[cand_s] ? IW'(cand_s) : idx;
    end
  end

endmodule

// File: rtl/add_fed_sched.sv
// Round-robin scheduler that time-shares one add_fed accumulator between N_REQ requesters.
// Each job: clear the accumulator, stream len samples into it, report the sum.
module add_fed_sched
  import add_fed_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ*W-1:0]     din,
  output logic [N_REQ-1:0]       take,
  output logic [N_REQ-1:0]       done,
  output logic [W-1:0]           result,
  output logic                   busy,
  output logic [W-1:0]           acc_din,
  output logic                   acc_clr,
  input  logic [W-1:0]           acc_dout
);

  localparam int               IW  = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t           state_r;
  logic [IW-1:0]    ptr_r;
  logic [IW-1:0]    gnt_r;
  logic [LEN_W-1:0] cnt_r;
  logic             pick_valid_s;
  logic [IW-1:0]    pick_idx_s;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Job sequencer; every control output is registered alongside the state
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      gnt_r   <= '0;
      cnt_r   <= '0;
      take    <= '0;
      done    <= '0;
      result  <= '0;
      busy    <= 1'b0;
      acc_clr <= 1'b0;
    end else begin
      done <= '0;
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            gnt_r   <= pick_idx_s;
            cnt_r   <= len[pick_idx_s*LEN_W +: LEN_W];
            acc_clr <= 1'b1;
            busy    <= 1'b1;
            state_r <= CLR;
          end
        end
        CLR: begin
          acc_clr <= 1'b0;
          if (cnt_r != '0) begin
            take    <= ONE << gnt_r;
            state_r <= RUN;
          end else begin
            state_r <= DONE;
          end
        end
        RUN: begin
          cnt_r <= cnt_r - LEN_W'(1);
          if (cnt_r == LEN_W'(1)) begin
            take    <= '0;
            state_r <= DONE;
          end
        end
        DONE: begin
          // acc_dout now holds the last sample added at the RUN exit edge
          result  <= acc_dout;
          done    <= ONE << gnt_r;
          ptr_r   <= (gnt_r == IW'(N_REQ - 1)) ? '0 : gnt_r + IW'(1);
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          take    <= '0;
          busy    <= 1'b0;
          acc_clr <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // take is nonzero only in RUN, so the accumulator sees zero at all other times
  always_comb begin
    if (take != '0) acc_din = din[gnt_r*W +: W];
    else            acc_din = '0;
  end

endmodule

// File: tb/tb_add_fed_sched.sv
// Directed bench for add_fed_sched with a job-timeline reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_add_fed_sched;

  localparam int N = 4;
  localparam int W = 16;
  localparam int LW = 4;

  logic            clk;
  logic            res;
  logic [N-1:0]    req;
  logic [N*LW-1:0] len;
  logic [N*W-1:0]  din;
  logic [N-1:0]    take;
  logic [N-1:0]    done;
  logic [W-1:0]    result;
  logic            busy;
  logic [W-1:0]    acc_din;
  logic            acc_clr;
  logic [W-1:0]    acc_dout;

  int checks = 0;
  int errors = 0;

  add_fed_sched #(.N_REQ(N), .W(W), .LEN_W(LW)) dut (
    .clk(clk), .res(res), .req(req), .len(len), .din(din),
    .take(take), .done(done), .result(result), .busy(busy),
    .acc_din(acc_din), .acc_clr(acc_clr), .acc_dout(acc_dout)
  );

  add_fed #(.W(W)) acc (.clk(clk), .res(acc_clr), .din(acc_din), .dout(acc_dout));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-requester sample lists; the feeder advances one sample per consumed take
  logic [W-1:0] smp [N][8];
  int           sidx [N];

  task automatic load(input int i, input int l, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c);
    for (int k = 0; k < 8; k++) smp[i][k] = '0;
    smp[i][0] = a; smp[i][1] = b; smp[i][2] = c;
    sidx[i] = 0;
    len[i*LW +: LW] = LW'(l);
    din[i*W +: W] = a;
  endtask

  initial begin
    logic [N-1:0] tk;
    forever begin
      @(negedge clk);
      tk = take;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (tk[i] && sidx[i] < 7) sidx[i]++;
        din[i*W +: W] = smp[i][sidx[i]];
      end
    end
  end

  // Reference model: a granted job occupies a fixed timeline relative to its grant cycle
  int           cyc = 0;
  bit           m_act = 0;
  int           m_t0, m_len, m_g;
  int           m_ptr = 0;
  logic [W-1:0] m_sum, m_result = '0;
  int           tc [N];

  always @(negedge clk) begin
    logic [N-1:0] e_take, e_done;
    logic         e_busy, e_clr;
    logic [W-1:0] e_din;
    e_take = '0; e_done = '0; e_busy = 1'b0; e_clr = 1'b0; e_din = '0;
    if (res) begin
      m_act = 0; m_result = '0; m_ptr = 0;
    end else if (m_act) begin
      e_busy = (cyc >= m_t0 + 1) && (cyc <= m_t0 + m_len + 2);
      e_clr  = (cyc == m_t0 + 1);
      if (cyc >= m_t0 + 2 && cyc <= m_t0 + m_len + 1) begin
        e_take[m_g] = 1'b1;
        e_din = din[m_g*W +: W];
        m_sum = m_sum + e_din;
      end
      if (cyc == m_t0 + m_len + 3) begin
        e_done[m_g] = 1'b1;
        m_result = m_sum;
        m_ptr = (m_g + 1) % N;
        m_act = 0;
      end
    end
    chk("take", take, e_take);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("acc_clr", acc_clr, e_clr);
    chk("acc_din", acc_din, e_din);
    chk("result", result, m_result);
    for (int i = 0; i < N; i++) if (take[i]) tc[i]++;
    if (!res && !m_act && req != '0) begin
      bit found;
      found = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && req[c]) begin
          found = 1; m_g = c;
        end
      end
      m_act = 1; m_t0 = cyc; m_len = int'(len[m_g*LW +: LW]); m_sum = '0;
    end
    cyc++;
  end

  task automatic wait_done(input int i, input int maxc, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (!done[i] && lat < maxc);
    chk("done_timeout", done[i], 1'b1);
  endtask

  task automatic wait_any(input int maxc, output logic [N-1:0] dv);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (done == '0 && n < maxc);
    dv = done;
  endtask

  initial begin
    int           lat;
    logic [N-1:0] dv;
    logic [W-1:0] r0, a0;
    res = 1'b1; req = '0; len = '0; din = '0;
    for (int i = 0; i < N; i++) begin
      sidx[i] = 0; tc[i] = 0;
      for (int k = 0; k < 8; k++) smp[i][k] = '0;
    end
    repeat (3) @(posedge clk);
    #2 res = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_take", take, 4'b0000);
    @(posedge clk); #2;

    // Contention from ptr=0: requester 0 first, then 1
    load(0, 2, 16'd1, 16'd1, 16'd0);
    load(1, 2, 16'd7, 16'd7, 16'd0);
    req = 4'b0011;
    wait_done(0, 20, lat);
    chk("cont_r0", result, 16'd2);
    req[0] = 1'b0;
    wait_done(1, 20, lat);
    chk("cont_r1", result, 16'd14);
    req[1] = 1'b0;
    // ptr now 2: requester 2 beats a re-asserting requester 0
    load(0, 1, 16'd4, 16'd0, 16'd0);
    load(2, 1, 16'd3, 16'd0, 16'd0);
    @(posedge clk); #2;
    req = 4'b0101;
    wait_any(20, dv);
    chk("rot_order", dv, 4'b0100);
    chk("rot_r2", result, 16'd3);
    req[2] = 1'b0;
    wait_done(0, 20, lat);
    chk("rot_r0", result, 16'd4);
    req[0] = 1'b0;

    // Single job: 12+10+5
    @(posedge clk); #2;
    load(0, 3, 16'd12, 16'd10, 16'd5);
    tc[0] = 0;
    req = 4'b0001;
    wait_done(0, 20, lat);
    chk("single_lat", lat, 6);
    chk("single_res", result, 16'd27);
    chk("single_takes", tc[0], 3);
    req = '0;

    // Wrap modulo 2^16
    @(posedge clk); #2;
    load(3, 2, 16'hFFFF, 16'h0002, 16'd0);
    req = 4'b1000;
    wait_done(3, 20, lat);
    chk("wrap_res", result, 16'h0001);
    req = '0;

    // Zero-length job
    @(posedge clk); #2;
    load(1, 0, 16'h1234, 16'd0, 16'd0);
    tc[1] = 0;
    req = 4'b0010;
    wait_done(1, 20, lat);
    chk("zero_lat", lat, 3);
    chk("zero_res", result, 16'h0000);
    chk("zero_takes", tc[1], 0);
    req = '0;

    // Idle hygiene: nothing moves for 20 cycles
    @(posedge clk); #2;
    r0 = result; a0 = acc_dout;
    repeat (20) begin
      @(posedge clk); #2;
      chk("idle_dout", acc_dout, a0);
      chk("idle_result", result, r0);
    end

    // Reset during the second RUN cycle of a len=5 job
    load(2, 5, 16'd1, 16'd2, 16'd3);
    req = 4'b0100;
    repeat (3) @(posedge clk);
    #2 res = 1'b1;
    #1;
    chk("mid_take", take, 4'b0000);
    chk("mid_busy", busy, 1'b0);
    chk("mid_din", acc_din, 16'h0000);
    chk("mid_result", result, 16'h0000);
    req = '0;
    repeat (2) @(posedge clk);
    #2 res = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    load(1, 1, 16'd9, 16'd0, 16'd0);
    req = 4'b0010;
    wait_done(1, 20, lat);
    chk("fresh_lat", lat, 4);
    chk("fresh_res", result, 16'd9);
    req = '0;
    repeat (5) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
